// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and bit-mixing helpers for the stream core.
package sha256_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCompute,
      StUpdate,
      StOutput,
      StRehash
   } state_e;

   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed {a,b,c,d,e,f,g,h}, a in the MSBs.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] state_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] state_out
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   assign {a, b, c, d, e, f, g, h} = state_in;

   assign t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
   assign t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));

   assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 block engine fed with pre-padded 16-word blocks.
// Optional double hashing (SHA-256 of the digest) is compiled in by SHA256_DOUBLE_HASH_EN.
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_word,
   input  logic         in_first,
   input  logic         in_last,
`ifdef SHA256_DOUBLE_HASH_EN
   input  logic         in_double,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   localparam int unsigned NumCycles = 64 / ROUNDS_PER_CYCLE;
   localparam logic [5:0]  LastCycle = 6'(NumCycles - 1);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end

   state_e        state_q, state_d;
   logic [255:0]  wk_q, h_q;
   logic [511:0]  w_q;           // schedule window, word 0 (oldest) in bits 31:0
   logic [3:0]    cnt_q;
   logic [5:0]    rnd_q;
   logic          last_q, dbl_q, live_q;
   logic          dbl_in, accept;
   logic [255:0]  h_sum, st_next;
   logic [511:0]  win_next, dbl_blk;

`ifdef SHA256_DOUBLE_HASH_EN
   assign dbl_in = in_double;
`else
   assign dbl_in = 1'b0;
`endif

   assign accept = in_valid && in_ready;

   // Each round consumes window word 0 and shifts in W[t+16].
   for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
      logic [255:0] st_in, st_out;
      logic [511:0] win_in, win_out;
      logic [31:0]  w_new;
      logic [5:0]   t;

      if (r == 0) begin : g_head
         assign st_in  = wk_q;
         assign win_in = w_q;
      end else begin : g_link
         assign st_in  = g_round[r-1].st_out;
         assign win_in = g_round[r-1].win_out;
      end

      assign t       = rnd_q * 6'(ROUNDS_PER_CYCLE) + 6'(r);
      assign w_new   = sigma1(win_in[14*32 +: 32]) + win_in[9*32 +: 32] +
                       sigma0(win_in[32 +: 32]) + win_in[31:0];
      assign win_out = {w_new, win_in[511:32]};

      sha256_round u_round (
         .state_in  (st_in),
         .k         (K[t]),
         .w         (win_in[31:0]),
         .state_out (st_out)
      );
   end

   assign st_next  = g_round[ROUNDS_PER_CYCLE-1].st_out;
   assign win_next = g_round[ROUNDS_PER_CYCLE-1].win_out;

   always_comb begin
      h_sum   = '0;
      dbl_blk = {32'd256, 192'd0, 32'h80000000, 256'd0};
      for (int i = 0; i < 8; i++) begin
         h_sum[32*i +: 32]   = h_q[32*i +: 32] + wk_q[32*i +: 32];
         dbl_blk[32*i +: 32] = h_q[255-32*i -: 32];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (accept) state_d = StLoad;
         StLoad:    if (accept && cnt_q == 4'd15) state_d = StCompute;
         StCompute: if (rnd_q == LastCycle) state_d = StUpdate;
         StUpdate: begin
            if (dbl_q)       state_d = StRehash;
            else if (last_q) state_d = StOutput;
            else             state_d = StIdle;
         end
         StRehash:  state_d = StCompute;
         StOutput:  if (out_ready) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wk_q   <= '0;
         h_q    <= '0;
         w_q    <= '0;
         cnt_q  <= '0;
         rnd_q  <= '0;
         last_q <= 1'b0;
         dbl_q  <= 1'b0;
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
         case (state_q)
            StIdle, StLoad: begin
               if (accept) begin
                  w_q   <= {in_word, w_q[511:32]};
                  cnt_q <= cnt_q + 4'd1;
                  if (state_q == StIdle) begin
                     cnt_q <= 4'd1;
                     dbl_q <= dbl_in;
                     wk_q  <= in_first ? IV : h_q;
                     if (in_first) h_q <= IV;
                  end else if (cnt_q == 4'd15) begin
                     last_q <= in_last;
                  end
               end
            end
            StCompute: begin
               wk_q  <= st_next;
               w_q   <= win_next;
               rnd_q <= (rnd_q == LastCycle) ? 6'd0 : rnd_q + 6'd1;
            end
            StUpdate: h_q <= h_sum;
            StRehash: begin
               w_q   <= dbl_blk;
               wk_q  <= IV;
               h_q   <= IV;
               dbl_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // live_q keeps in_ready low while reset is asserted and until the first clock after it.
   assign in_ready   = live_q && (state_q == StIdle || state_q == StLoad);
   assign out_valid  = (state_q == StOutput);
   assign out_digest = out_valid ? h_q : '0;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: directed known-answer blocks, latency,
// backpressure and reset-abort cases.
module tb_sha256_stream_core;

   localparam int RPC = 4;
   localparam int LAT = 64 / RPC + 2;

   localparam logic [511:0] ABC = 512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
   localparam logic [511:0] NIST1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
   localparam logic [511:0] NIST2 = 512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;
   localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] NIST_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DBL_D  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid, in_ready, in_first, in_last, in_double;
   logic [31:0]  in_word;
   logic         out_valid, out_ready, busy;
   logic [255:0] out_digest;

   typedef struct {
      logic [255:0] dig;
      int           rise;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   logic prev_ov = 1'b0;

   sha256_stream_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .in_first   (in_first),
      .in_last    (in_last),
`ifdef SHA256_DOUBLE_HASH_EN
      .in_double  (in_double),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digest (out_digest),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: compares every presented digest and its arrival cycle against the queue head.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid) begin
            check("in_ready_low_in_output", in_ready, 1'b0);
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
               if (!prev_ov) check("out_valid_latency", cyc, exp_q[0].rise);
               check("digest", out_digest, exp_q[0].dig);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic put_word(input logic [31:0] w, input logic f, input logic l, input logic d,
                           output int acc);
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_word   = w;
      in_first  = f;
      in_last   = l;
      in_double = d;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         $display("FAIL in_ready_timeout: got 0 expected 1");
         $fatal(1, "in_ready never rose");
      end
      acc = cyc;
      @(posedge clk);
   endtask

   task automatic send_block(input logic [511:0] blk, input logic f, input logic l,
                             input logic d, input logic push, input logic [255:0] dig,
                             input int lat, input logic gaps);
      int acc = 0;
      for (int i = 0; i < 16; i++) begin
         if (gaps && (i % 3 == 1)) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         put_word(blk[511-32*i -: 32], f && (i == 0), l && (i == 15), d && (i == 0), acc);
      end
      #1 in_valid = 1'b0;
      if (push) exp_q.push_back('{dig, acc + lat});
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_word   = '0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_double = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_digest", out_digest, '0);
      reset_n = 1'b1;
      #1 check("in_ready_before_first_clk", in_ready, 1'b0);
      @(negedge clk);
      check("in_ready_first_clk", in_ready, 1'b1);

      // Back-to-back messages, including a two-block one.
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b0);
      send_block(NIST1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
      send_block(NIST2, 1'b0, 1'b1, 1'b0, 1'b1, NIST_D, LAT, 1'b0);
      // in_valid gaps, then a restart via in_first after a non-final block.
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b1);
      send_block(NIST1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b0);
      drain();

      // Output backpressure for 20 cycles.
      out_ready = 1'b0;
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b0);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("bp_out_valid_seen", out_valid, 1'b1);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("in_ready_after_handshake", in_ready, 1'b1);
      check("out_valid_after_handshake", out_valid, 1'b0);
      drain();

      // Reset mid-COMPUTE aborts the block without residue.
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
      repeat (4) @(negedge clk);
      check("busy_in_compute", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_out_digest", out_digest, '0);
      @(negedge clk);
      reset_n = 1'b1;
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b0);
      drain();

`ifdef SHA256_DOUBLE_HASH_EN
      send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b1, DBL_D, 2 * LAT, 1'b0);
      send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b1, ABC_D, LAT, 1'b0);
      drain();
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
